// File: rtl/rdmx_addr_sequencer.sv
// Sequences expected RDMX frame-data / meta-data target addresses, one beat per frame-data packet.
// Define RDMX_SEQ_FRAME_COUNTER_EN to add the frame-counter write beat (fc_*) issued after each frame.
module rdmx_addr_sequencer #(
  parameter int unsigned MD_BYTES = 64,
  parameter int unsigned FNUM_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [63:0]       RFD_ADDR,
  input  logic [63:0]       RFD_SIZE,
  input  logic [63:0]       RMD_ADDR,
  input  logic [63:0]       RMD_SIZE,
  input  logic [31:0]       FRAME_SIZE,
  input  logic [15:0]       PACKET_SIZE,
  input  logic [31:0]       PACKETS_PER_GROUP,
`ifdef RDMX_SEQ_FRAME_COUNTER_EN
  input  logic [63:0]       RFC_ADDR,
  output logic              fc_valid,
  output logic [63:0]       fc_addr,
  output logic [FNUM_W-1:0] fc_data,
  input  logic              fc_ready,
`endif
  output logic              m_valid,
  input  logic              m_ready,
  output logic [63:0]       m_fd_addr,
  output logic [15:0]       m_len,
  output logic [63:0]       m_md_addr,
  output logic [FNUM_W-1:0] m_frame_num,
  output logic              m_last_frame,
  output logic              m_last_group,
  output logic              busy,
  output logic              cfg_error
);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_RUN, S_ERROR} state_e;

  localparam logic [63:0]       MD_STEP  = 64'(MD_BYTES);
  localparam logic [FNUM_W-1:0] FNUM_ONE = FNUM_W'(1);

  state_e state_q, state_d;

  logic [63:0]       rfd_addr_q, rfd_size_q, rmd_addr_q, rmd_size_q;
  logic [31:0]       frame_size_q, ppg_q;
  logic [15:0]       pkt_size_q;
  logic [31:0]       foff_q, gcnt_q;
  logic [63:0]       fbase_q, mdoff_q;
  logic [FNUM_W-1:0] frame_num_q;
  logic              m_valid_q, m_valid_d;
  logic              stop_pend_q, stop_pend_d;
  logic              cfg_error_q, cfg_error_d;
  logic              latch_cfg, advance;

  logic [31:0] remaining;
  logic [15:0] beat_len;
  logic        last_frame, last_group, accept, cfg_ok, fd_wrap, md_wrap;
  logic        stop_req, fc_hold, fc_done;

  assign remaining  = frame_size_q - foff_q;
  assign beat_len   = (remaining < 32'(pkt_size_q)) ? remaining[15:0] : pkt_size_q;
  assign last_frame = (33'(foff_q) + 33'(pkt_size_q)) >= 33'(frame_size_q);
  assign last_group = (ppg_q != '0) && ((gcnt_q == ppg_q - 32'd1) || last_frame);
  assign accept     = m_valid_q && m_ready;
  assign stop_req   = stop || stop_pend_q;
  assign cfg_ok     = (pkt_size_q != '0) && (frame_size_q != '0) &&
                      (rfd_size_q >= 64'(frame_size_q)) && (rmd_size_q >= MD_STEP);
  // Rings hold whole frames/records only: wrap when the following slot would not fit.
  assign fd_wrap    = (65'(fbase_q) + (65'(frame_size_q) << 1)) > 65'(rfd_size_q);
  assign md_wrap    = (65'(mdoff_q) + (65'(MD_STEP) << 1)) > 65'(rmd_size_q);

`ifdef RDMX_SEQ_FRAME_COUNTER_EN
  logic [63:0]       rfc_addr_q;
  logic              fc_valid_q;
  logic [FNUM_W-1:0] fc_data_q;

  // Packet beats pause while a counter write is about to issue or is waiting for fc_ready.
  assign fc_hold = (accept && last_frame) || (fc_valid_q && !fc_ready);
  assign fc_done = !(accept && last_frame) && (!fc_valid_q || fc_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      rfc_addr_q <= '0;
      fc_valid_q <= 1'b0;
      fc_data_q  <= '0;
    end else begin
      if (latch_cfg) rfc_addr_q <= RFC_ADDR;
      if (advance && last_frame) begin
        fc_valid_q <= 1'b1;
        fc_data_q  <= frame_num_q + FNUM_ONE;
      end else if (fc_ready) begin
        fc_valid_q <= 1'b0;
      end
    end
  end

  assign fc_valid = fc_valid_q;
  assign fc_addr  = rfc_addr_q;
  assign fc_data  = fc_data_q;
`else
  assign fc_hold = 1'b0;
  assign fc_done = 1'b1;
`endif

  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch can be inferred.
    state_d     = state_q;
    m_valid_d   = m_valid_q;
    stop_pend_d = stop_pend_q;
    cfg_error_d = cfg_error_q;
    latch_cfg   = 1'b0;
    advance     = 1'b0;
    case (state_q)
      S_IDLE, S_ERROR: begin
        if (start) begin
          state_d     = S_CHECK;
          latch_cfg   = 1'b1;
          cfg_error_d = 1'b0;
        end
      end
      S_CHECK: begin
        state_d     = cfg_ok ? S_RUN : S_ERROR;
        cfg_error_d = !cfg_ok;
      end
      S_RUN: begin
        advance = accept;
        if (stop_req && (!m_valid_q || accept) && fc_done) begin
          state_d     = S_IDLE;
          m_valid_d   = 1'b0;
          stop_pend_d = 1'b0;
        end else begin
          stop_pend_d = stop_req;
          m_valid_d   = (m_valid_q && !accept) || (!stop_req && !fc_hold);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only, so every process sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      m_valid_q    <= 1'b0;
      stop_pend_q  <= 1'b0;
      cfg_error_q  <= 1'b0;
      rfd_addr_q   <= '0;
      rfd_size_q   <= '0;
      rmd_addr_q   <= '0;
      rmd_size_q   <= '0;
      frame_size_q <= '0;
      pkt_size_q   <= '0;
      ppg_q        <= '0;
      foff_q       <= '0;
      fbase_q      <= '0;
      mdoff_q      <= '0;
      frame_num_q  <= '0;
      gcnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      m_valid_q   <= m_valid_d;
      stop_pend_q <= stop_pend_d;
      cfg_error_q <= cfg_error_d;
      if (latch_cfg) begin
        rfd_addr_q   <= RFD_ADDR;
        rfd_size_q   <= RFD_SIZE;
        rmd_addr_q   <= RMD_ADDR;
        rmd_size_q   <= RMD_SIZE;
        frame_size_q <= FRAME_SIZE;
        pkt_size_q   <= PACKET_SIZE;
        ppg_q        <= PACKETS_PER_GROUP;
        foff_q       <= '0;
        fbase_q      <= '0;
        mdoff_q      <= '0;
        frame_num_q  <= '0;
        gcnt_q       <= '0;
      end else if (advance) begin
        gcnt_q <= last_group ? '0 : gcnt_q + 32'd1;
        if (last_frame) begin
          foff_q      <= '0;
          frame_num_q <= frame_num_q + FNUM_ONE;
          fbase_q     <= fd_wrap ? '0 : fbase_q + 64'(frame_size_q);
          mdoff_q     <= md_wrap ? '0 : mdoff_q + MD_STEP;
        end else begin
          foff_q <= foff_q + 32'(pkt_size_q);
        end
      end
    end
  end

  // Beat fields read as zero whenever no beat is offered, which also keeps them zero out of reset.
  assign m_valid      = m_valid_q;
  assign m_fd_addr    = m_valid_q ? rfd_addr_q + fbase_q + 64'(foff_q) : '0;
  assign m_len        = m_valid_q ? beat_len : '0;
  assign m_md_addr    = m_valid_q ? rmd_addr_q + mdoff_q : '0;
  assign m_frame_num  = m_valid_q ? frame_num_q : '0;
  assign m_last_frame = m_valid_q && last_frame;
  assign m_last_group = m_valid_q && last_group;
  assign busy         = (state_q != S_IDLE);
  assign cfg_error    = cfg_error_q;

endmodule

// File: tb/tb_rdmx_addr_sequencer.sv
// Directed self-checking bench for rdmx_addr_sequencer; covers the frame-counter beat when
// RDMX_SEQ_FRAME_COUNTER_EN is defined.
module tb_rdmx_addr_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, stop, m_ready;
  logic [63:0] RFD_ADDR, RFD_SIZE, RMD_ADDR, RMD_SIZE;
  logic [31:0] FRAME_SIZE, PACKETS_PER_GROUP;
  logic [15:0] PACKET_SIZE;
  logic        m_valid, m_last_frame, m_last_group, busy, cfg_error;
  logic [63:0] m_fd_addr, m_md_addr;
  logic [15:0] m_len;
  logic [31:0] m_frame_num;
`ifdef RDMX_SEQ_FRAME_COUNTER_EN
  logic [63:0] RFC_ADDR, fc_addr;
  logic        fc_valid, fc_ready;
  logic [31:0] fc_data;
`endif

  int checks = 0;
  int errors = 0;
  int idx;

  always #5 clk = ~clk;

  rdmx_addr_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .RFD_ADDR(RFD_ADDR), .RFD_SIZE(RFD_SIZE), .RMD_ADDR(RMD_ADDR), .RMD_SIZE(RMD_SIZE),
    .FRAME_SIZE(FRAME_SIZE), .PACKET_SIZE(PACKET_SIZE), .PACKETS_PER_GROUP(PACKETS_PER_GROUP),
`ifdef RDMX_SEQ_FRAME_COUNTER_EN
    .RFC_ADDR(RFC_ADDR), .fc_valid(fc_valid), .fc_addr(fc_addr), .fc_data(fc_data), .fc_ready(fc_ready),
`endif
    .m_valid(m_valid), .m_ready(m_ready), .m_fd_addr(m_fd_addr), .m_len(m_len),
    .m_md_addr(m_md_addr), .m_frame_num(m_frame_num), .m_last_frame(m_last_frame),
    .m_last_group(m_last_group), .busy(busy), .cfg_error(cfg_error)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_beat(input string tag, input logic [63:0] fd, input logic [15:0] len,
                            input logic [63:0] md, input int fn, input logic lf, input logic lg);
    check({tag, " valid"}, 64'(m_valid), 64'd1);
    check({tag, " fd"}, m_fd_addr, fd);
    check({tag, " len"}, 64'(m_len), 64'(len));
    check({tag, " md"}, m_md_addr, md);
    check({tag, " fnum"}, 64'(m_frame_num), 64'(fn));
    check({tag, " last_frame"}, 64'(m_last_frame), 64'(lf));
    check({tag, " last_group"}, 64'(m_last_group), 64'(lg));
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " valid"}, 64'(m_valid), 64'd0);
    check({tag, " fd"}, m_fd_addr, 64'd0);
    check({tag, " len"}, 64'(m_len), 64'd0);
    check({tag, " md"}, m_md_addr, 64'd0);
    check({tag, " fnum"}, 64'(m_frame_num), 64'd0);
    check({tag, " lf/lg"}, 64'({m_last_frame, m_last_group}), 64'd0);
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " cfg_error"}, 64'(cfg_error), 64'd0);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 10 && m_valid !== 1'b1; i++) tick();
    check({tag, " wait valid"}, 64'(m_valid), 64'd1);
  endtask

  task automatic set_cfg(input logic [63:0] fa, input logic [63:0] fs, input logic [63:0] ma,
                         input logic [63:0] ms, input logic [31:0] fr, input logic [15:0] pk,
                         input logic [31:0] pg);
    RFD_ADDR = fa; RFD_SIZE = fs; RMD_ADDR = ma; RMD_SIZE = ms;
    FRAME_SIZE = fr; PACKET_SIZE = pk; PACKETS_PER_GROUP = pg;
  endtask

  // Test-1 configuration: 8 packets/frame, 4 frames per ring, groups of 4, md +64/frame.
  function automatic logic [63:0] t1_fd(input int k);
    return 64'h1000_0000 + 64'(((k / 8) % 4) * 32'h8000) + 64'((k % 8) * 32'h1000);
  endfunction

  task automatic t1_beat(input string tag, input int k);
    check_beat($sformatf("%s[%0d]", tag, k), t1_fd(k), 16'h1000,
               64'h4000_0000 + 64'((k / 8) * 64), k / 8, (k % 8) == 7, ((k % 8) == 3) || ((k % 8) == 7));
  endtask

  logic [63:0] t2_fd_even [3];
  logic [63:0] t2_fd_odd  [3];

  initial begin
    t2_fd_even = '{64'hFFFF_FFFF_FFFF_E000, 64'hFFFF_FFFF_FFFF_F000, 64'h0};
    t2_fd_odd  = '{64'h800, 64'h1800, 64'h2800};
    reset = 1'b1; start = 1'b0; stop = 1'b0; m_ready = 1'b0;
    set_cfg(64'h1000_0000, 64'h2_0000, 64'h4000_0000, 64'h1_0000, 32'h8000, 16'h1000, 32'd4);
`ifdef RDMX_SEQ_FRAME_COUNTER_EN
    RFC_ADDR = 64'h5000_0000; fc_ready = 1'b0;
`endif
    tick(); tick();
    check_quiet("reset");
    reset = 1'b0;

    // Test 1: basic sequence, ring wrap at frame 4, then stop while stalled.
    m_ready = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    check("t1 busy@check", 64'(busy), 64'd1);
    check("t1 valid@check", 64'(m_valid), 64'd0);
    tick();
    check("t1 valid@run entry", 64'(m_valid), 64'd0);
    tick();
    for (int k = 0; k < 40; k++) begin
      t1_beat("t1", k);
      if (k == 32) check("t1 ring wrap fd", m_fd_addr, 64'h1000_0000);
      tick();
    end
    m_ready = 1'b0; stop = 1'b1;
    tick(); stop = 1'b0;
    check("t1 stop pending busy", 64'(busy), 64'd1);
    check("t1 stop pending fd held", m_fd_addr, 64'h1000_8000);
    m_ready = 1'b1;
    tick();
    check("t1 stop idle busy", 64'(busy), 64'd0);
    check("t1 stop idle valid", 64'(m_valid), 64'd0);

    // Test 4: rejected configs, cfg_error sticky then cleared by start.
    PACKET_SIZE = 16'h0; start = 1'b1;
    tick(); start = 1'b0;
    check("t4 err cleared at start", 64'(cfg_error), 64'd0);
    tick();
    check("t4 pkt0 cfg_error", 64'(cfg_error), 64'd1);
    check("t4 pkt0 busy", 64'(busy), 64'd1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t4 pkt0 no valid %0d", i), 64'(m_valid), 64'd0);
      tick();
    end
    PACKET_SIZE = 16'h1000; RFD_SIZE = 64'h4000; start = 1'b1;
    tick(); start = 1'b0;
    check("t4 restart clears err", 64'(cfg_error), 64'd0);
    tick();
    check("t4 small ring cfg_error", 64'(cfg_error), 64'd1);
    check("t4 small ring valid", 64'(m_valid), 64'd0);

    // Test 2 from ERROR: short final packet, 64-bit address wrap, md ring wrap, groups of 2.
    set_cfg(64'hFFFF_FFFF_FFFF_E000, 64'h6000, 64'h3000_0000, 64'd128, 32'h2800, 16'h1000, 32'd2);
    start = 1'b1;
    tick(); start = 1'b0;
    check("t2 good start clears err", 64'(cfg_error), 64'd0);
    tick(); tick();
    for (int k = 0; k < 10; k++) begin
      check_beat($sformatf("t2[%0d]", k), ((k / 3) % 2 == 0) ? t2_fd_even[k % 3] : t2_fd_odd[k % 3],
                 (k % 3 == 2) ? 16'h0800 : 16'h1000,
                 ((k / 3) % 2 == 0) ? 64'h3000_0000 : 64'h3000_0040,
                 k / 3, (k % 3) == 2, (k % 3) != 0);
      start = (k == 1);
      if (k == 1) PACKET_SIZE = 16'h0400;
      stop = (k == 9);
      tick();
    end
    start = 1'b0; stop = 1'b0;
    check("t2 stop+accept busy", 64'(busy), 64'd0);
    check("t2 stop+accept valid", 64'(m_valid), 64'd0);
    tick();
    check("t2 no further beat", 64'(m_valid), 64'd0);

    // Test 3: random backpressure against the test-1 sequence.
    set_cfg(64'h1000_0000, 64'h2_0000, 64'h4000_0000, 64'h1_0000, 32'h8000, 16'h1000, 32'd4);
    start = 1'b1;
    tick(); start = 1'b0;
    idx = 0;
    for (int c = 0; c < 600 && idx < 40; c++) begin
      m_ready = 1'($urandom_range(0, 1));
      if (m_valid) begin
        t1_beat("t3", idx);
        if (m_ready) idx++;
      end
      tick();
    end
    check("t3 beats accepted", 64'(idx), 64'd40);
    m_ready = 1'b0;
    tick();
    check("t3 stalled beat fd", m_fd_addr, t1_fd(40));

    // Test 5b: reset during a stall abandons the beat.
    reset = 1'b1;
    tick(); reset = 1'b0;
    check_quiet("t5 reset mid-stall");

    // Test 5a: stop coincident with accept of beat 5.
    m_ready = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    wait_valid("t5");
    for (int k = 0; k < 6; k++) begin
      t1_beat("t5", k);
      stop = (k == 5);
      tick();
    end
    stop = 1'b0;
    check("t5 busy after stop", 64'(busy), 64'd0);
    check("t5 valid after stop", 64'(m_valid), 64'd0);
    tick();
    check("t5 still idle", 64'(busy), 64'd0);

`ifdef RDMX_SEQ_FRAME_COUNTER_EN
    // Test 6: counter write after frame 0 holds packet beats until fc_ready.
    set_cfg(64'h1000_0000, 64'h4000, 64'h4000_0000, 64'h1_0000, 32'h1000, 16'h1000, 32'd0);
    fc_ready = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    wait_valid("t6");
    check_beat("t6 f0", 64'h1000_0000, 16'h1000, 64'h4000_0000, 0, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t6 hold valid %0d", i), 64'(m_valid), 64'd0);
      check($sformatf("t6 fc_valid %0d", i), 64'(fc_valid), 64'd1);
      check($sformatf("t6 fc_data %0d", i), 64'(fc_data), 64'd1);
      check($sformatf("t6 fc_addr %0d", i), fc_addr, 64'h5000_0000);
      tick();
    end
    fc_ready = 1'b1;
    tick();
    check("t6 fc done", 64'(fc_valid), 64'd0);
    check_beat("t6 f1", 64'h1000_1000, 16'h1000, 64'h4000_0040, 1, 1'b1, 1'b0);
    reset = 1'b1;
    tick(); reset = 1'b0;
    check("t6 reset fc_valid", 64'(fc_valid), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
